// File: rtl/ad7606_par_ctrl.sv
// AD7606 parallel-mode controller: chip reset, periodic CONVST, BUSY wait, CS/RD readout to a valid/ready stream.
// Define AD7606_FRSTDATA_CHK_EN to verify FRSTDATA on every captured word.
module ad7606_par_ctrl #(
    parameter int unsigned NUM_CH      = 8,
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned SAMPLE_DIV  = 250,
    parameter int unsigned RESET_CYC   = 16,
    parameter int unsigned CONVST_LOW  = 3,
    parameter int unsigned BUSY_SETTLE = 6,
    parameter int unsigned RD_LOW      = 2,
    parameter int unsigned RD_HIGH     = 2,
    parameter int unsigned BUSY_TMO    = 4096
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic [2:0]        os_cfg,
    input  logic              range_cfg,
    input  logic              err_clr,
    input  logic [DATA_W-1:0] ad_data,
    input  logic              ad_busy,
    input  logic              ad_frstdata,
    output logic [2:0]        ad_os,
    output logic              ad_range,
    output logic              ad_par_ser_n,
    output logic              ad_reset,
    output logic              ad_convst,
    output logic              ad_cs_n,
    output logic              ad_rd_n,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic [2:0]        m_ch,
    output logic              m_last,
    output logic              err_overrun,
    output logic              err_timeout,
    output logic              err_frst
);

    function automatic int unsigned max2(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

    localparam int unsigned SC_MAX = max2(max2(max2(RESET_CYC, CONVST_LOW), max2(BUSY_SETTLE, RD_LOW)),
                                          max2(RD_HIGH, BUSY_TMO));
    localparam int unsigned SC_W   = $clog2(SC_MAX + 1);
    localparam int unsigned PC_W   = $clog2(SAMPLE_DIV);

    typedef enum logic [2:0] {
        S_RST, S_IDLE, S_CONV, S_SETTLE, S_BUSYW, S_RDL, S_RDH, S_DONE
    } state_t;

    state_t            state;
    logic [SC_W-1:0]   sc;
    logic [PC_W-1:0]   pcnt;
    logic [2:0]        widx;
    logic              tick;
    logic              frst_bad;
    logic              err_frst_q;

    assign tick         = (pcnt == PC_W'(SAMPLE_DIV - 1));
    assign ad_par_ser_n = 1'b0;
    assign err_frst     = err_frst_q;

`ifdef AD7606_FRSTDATA_CHK_EN
    assign frst_bad = (widx == 3'd0) ? !ad_frstdata : ad_frstdata;
`else
    assign frst_bad = ad_frstdata & 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= S_RST;
            sc          <= '0;
            pcnt        <= '0;
            widx        <= '0;
            ad_reset    <= 1'b1;
            ad_convst   <= 1'b1;
            ad_cs_n     <= 1'b1;
            ad_rd_n     <= 1'b1;
            ad_os       <= '0;
            ad_range    <= 1'b1;
            m_valid     <= 1'b0;
            m_data      <= '0;
            m_ch        <= '0;
            m_last      <= 1'b0;
            err_overrun <= 1'b0;
            err_timeout <= 1'b0;
            err_frst_q  <= 1'b0;
        end else begin
            if (state == S_RST || tick)
                pcnt <= '0;
            else
                pcnt <= pcnt + 1'b1;

            if (m_valid && m_ready)
                m_valid <= 1'b0;

            // error sets below are later in the block, so a coincident set beats err_clr
            if (err_clr) begin
                err_overrun <= 1'b0;
                err_timeout <= 1'b0;
                err_frst_q  <= 1'b0;
            end
            if (tick && state != S_IDLE)
                err_overrun <= 1'b1;

            case (state)
                S_RST: begin
                    if (sc == SC_W'(RESET_CYC - 1)) begin
                        sc       <= '0;
                        ad_reset <= 1'b0;
                        state    <= S_IDLE;
                    end else begin
                        sc <= sc + 1'b1;
                    end
                end
                S_IDLE: begin
                    if (tick && enable) begin
                        ad_os     <= os_cfg;
                        ad_range  <= range_cfg;
                        ad_convst <= 1'b0;
                        sc        <= '0;
                        state     <= S_CONV;
                    end
                end
                S_CONV: begin
                    if (sc == SC_W'(CONVST_LOW - 1)) begin
                        ad_convst <= 1'b1;
                        sc        <= '0;
                        state     <= S_SETTLE;
                    end else begin
                        sc <= sc + 1'b1;
                    end
                end
                S_SETTLE: begin
                    if (sc == SC_W'(BUSY_SETTLE - 1)) begin
                        sc    <= '0;
                        state <= S_BUSYW;
                    end else begin
                        sc <= sc + 1'b1;
                    end
                end
                S_BUSYW: begin
                    if (!ad_busy) begin
                        ad_cs_n <= 1'b0;
                        ad_rd_n <= 1'b0;
                        widx    <= '0;
                        sc      <= '0;
                        state   <= S_RDL;
                    end else if (sc == SC_W'(BUSY_TMO - 1)) begin
                        err_timeout <= 1'b1;
                        ad_reset    <= 1'b1;
                        pcnt        <= '0;
                        sc          <= '0;
                        state       <= S_RST;
                    end else begin
                        sc <= sc + 1'b1;
                    end
                end
                S_RDL: begin
                    if (sc == SC_W'(RD_LOW - 1)) begin
                        ad_rd_n <= 1'b1;
                        sc      <= '0;
                        if (frst_bad) begin
                            err_frst_q <= 1'b1;
                            ad_cs_n    <= 1'b1;
                            state      <= S_IDLE;
                        end else begin
                            m_valid <= 1'b1;
                            m_data  <= ad_data;
                            m_ch    <= widx;
                            m_last  <= (widx == 3'(NUM_CH - 1));
                            state   <= S_RDH;
                        end
                    end else begin
                        sc <= sc + 1'b1;
                    end
                end
                S_RDH: begin
                    // sc saturates at RD_HIGH-1; leave only once the pending word is taken
                    if (sc != SC_W'(RD_HIGH - 1))
                        sc <= sc + 1'b1;
                    if (sc == SC_W'(RD_HIGH - 1) && (!m_valid || m_ready)) begin
                        sc <= '0;
                        if (widx == 3'(NUM_CH - 1)) begin
                            state <= S_DONE;
                        end else begin
                            widx    <= widx + 3'd1;
                            ad_rd_n <= 1'b0;
                            state   <= S_RDL;
                        end
                    end
                end
                S_DONE: begin
                    ad_cs_n <= 1'b1;
                    state   <= S_IDLE;
                end
                default: state <= S_RST;
            endcase
        end
    end

endmodule

// File: tb/tb_ad7606_par_ctrl.sv
// Bench for ad7606_par_ctrl: ADC pin model, frame scoreboard, directed sequences and randomized traffic.
module tb_ad7606_par_ctrl;

    localparam int NCH  = 8;
    localparam int SDIV = 250;
`ifdef AD7606_FRSTDATA_CHK_EN
    localparam bit FRST_CHK = 1'b1;
`else
    localparam bit FRST_CHK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0, enable = 1'b1, err_clr = 1'b0;
    logic [2:0]  os_cfg = 3'd5;
    logic        range_cfg = 1'b0;
    logic [15:0] ad_data = '0;
    logic        ad_busy = 1'b0, ad_frstdata = 1'b1, m_ready = 1'b1;
    logic [2:0]  ad_os, m_ch;
    logic        ad_range, ad_par_ser_n, ad_reset, ad_convst, ad_cs_n, ad_rd_n;
    logic        m_valid, m_last, err_overrun, err_timeout, err_frst;
    logic [15:0] m_data;

    always #5 clk = ~clk;

    ad7606_par_ctrl #(
        .NUM_CH(NCH), .DATA_W(16), .SAMPLE_DIV(SDIV), .RESET_CYC(16), .CONVST_LOW(3),
        .BUSY_SETTLE(6), .RD_LOW(2), .RD_HIGH(2), .BUSY_TMO(4096)
    ) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .os_cfg(os_cfg), .range_cfg(range_cfg),
        .err_clr(err_clr), .ad_data(ad_data), .ad_busy(ad_busy), .ad_frstdata(ad_frstdata),
        .ad_os(ad_os), .ad_range(ad_range), .ad_par_ser_n(ad_par_ser_n), .ad_reset(ad_reset),
        .ad_convst(ad_convst), .ad_cs_n(ad_cs_n), .ad_rd_n(ad_rd_n), .m_valid(m_valid),
        .m_ready(m_ready), .m_data(m_data), .m_ch(m_ch), .m_last(m_last),
        .err_overrun(err_overrun), .err_timeout(err_timeout), .err_frst(err_frst)
    );

    int n_tests = 0, n_fail = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    typedef struct {
        logic [15:0] d;
        int          ch;
        logic        last;
    } word_t;
    word_t exp_q[$];

    // ADC model: a conversion starts on CONVST fall; words are presented per RD strobe
    int          cyc = 0, n_conv = 0, last_conv_t = 0, prev_conv_t = 0;
    int          rdcnt = 0, busy_left = 0, busy_len = 20;
    bit          bad_frst = 1'b0, rand_mode = 1'b0;
    logic        conv_q = 1'b1, rd_q = 1'b1, rng_q = 1'b0;
    logic [2:0]  os_q = 3'd5;
    logic [15:0] vals [8];

    always @(posedge clk) cyc++;

    always @(negedge clk) begin : adc_model
        if (ad_reset) begin
            ad_busy = 1'b0;
            busy_left = 0;
            rdcnt = 0;
            exp_q.delete();
        end else begin
            if (conv_q && !ad_convst) begin
                chk("os_latch", ad_os, os_q);
                chk("range_latch", ad_range, rng_q);
                for (int i = 0; i < NCH; i++) begin
                    vals[i] = rand_mode ? 16'($urandom) : 16'(i + 1);
                    if (!(bad_frst && FRST_CHK))
                        exp_q.push_back('{d: vals[i], ch: i, last: (i == NCH - 1)});
                end
                rdcnt = 0;
                ad_busy = 1'b1;
                busy_left = rand_mode ? int'($urandom_range(2, 60)) : busy_len;
                n_conv++;
                prev_conv_t = last_conv_t;
                last_conv_t = cyc;
            end else if (busy_left > 0) begin
                busy_left--;
            end else begin
                ad_busy = 1'b0;
            end
            if (!rd_q && ad_rd_n) rdcnt++;
        end
        ad_data = vals[(rdcnt < NCH) ? rdcnt : NCH - 1];
        ad_frstdata = (rdcnt == 0) && !bad_frst;
        conv_q = ad_convst;
        rd_q = ad_rd_n;
        if (rand_mode) begin
            os_cfg = 3'($urandom);
            range_cfg = 1'($urandom);
        end
        os_q = os_cfg;
        rng_q = range_cfg;
    end

    // Scoreboard and m_ready driver: a handshake decided here completes at the next posedge
    int          n_words = 0, n_lasts = 0;
    int          stall_word = 0, stall_len = 0, stall_gen = 0, stall_seen = 0, stall_left = 0;
    bit          hs_p = 1'b0, stall_p = 1'b0;
    word_t       w_p;

    always @(negedge clk) begin : scoreboard
        word_t e;
        if (hs_p) begin
            n_words++;
            if (w_p.last) n_lasts++;
            chk("word_expected", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("m_data", w_p.d, e.d);
                chk("m_ch", w_p.ch, e.ch);
                chk("m_last", w_p.last, e.last);
            end
        end
        if (stall_p && rst_n) begin
            chk("hold_valid", m_valid, 1);
            chk("hold_data", m_data, w_p.d);
            chk("hold_ch", m_ch, w_p.ch);
            chk("rd_n_high_in_stall", ad_rd_n, 1);
        end
        if (stall_gen != stall_seen && m_valid && int'(m_ch) == stall_word) begin
            stall_seen = stall_gen;
            stall_left = stall_len;
        end
        if (stall_left > 0) begin
            m_ready = 1'b0;
            stall_left--;
        end else begin
            m_ready = rand_mode ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
        hs_p = m_valid && m_ready && rst_n;
        stall_p = m_valid && !m_ready;
        w_p = '{d: m_data, ch: int'(m_ch), last: m_last};
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_conv(input int lim, input string nm);
        int c0 = n_conv;
        for (int c = 0; c < lim && n_conv == c0; c++) step();
        chk(nm, n_conv > c0, 1);
    endtask

    task automatic wait_lasts(input int l0, input int lim, input string nm);
        for (int c = 0; c < lim && n_lasts <= l0; c++) step();
        chk(nm, n_lasts > l0, 1);
    endtask

    task automatic pulse_clr();
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
    endtask

    function automatic int count_high_reset();
        return 0;
    endfunction

    typedef struct {
        int word;
        int len;
        bit ovr;
    } stall_vec_t;
    stall_vec_t tbl [4];

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin : main
        int cnt, w0, l0, c0;
        tbl[0] = '{word: 3, len: 20,  ovr: 1'b0};
        tbl[1] = '{word: 0, len: 300, ovr: 1'b1};
        tbl[2] = '{word: 5, len: 100, ovr: 1'b0};
        tbl[3] = '{word: 7, len: 250, ovr: 1'b1};

        // reset values and chip reset width
        repeat (4) step();
        chk("rst_ad_reset", ad_reset, 1);
        chk("rst_convst", ad_convst, 1);
        chk("rst_cs_n", ad_cs_n, 1);
        chk("rst_rd_n", ad_rd_n, 1);
        chk("rst_m_valid", m_valid, 0);
        chk("rst_errs", {err_overrun, err_timeout, err_frst}, 0);
        chk("rst_os", ad_os, 0);
        chk("rst_range", ad_range, 1);
        chk("par_ser_n", ad_par_ser_n, 0);
        rst_n = 1'b1;
        cnt = 0;
        while (ad_reset && cnt < 100) begin cnt++; step(); end
        chk("reset_width", cnt, 16);
        cnt = 0;
        while (ad_convst && cnt < 1000) begin cnt++; step(); end
        chk("first_convst_delay", cnt, SDIV);
        cnt = 0;
        while (!ad_convst && cnt < 100) begin cnt++; step(); end
        chk("convst_width", cnt, 3);

        // directed frames: data 1..8, one frame per period
        l0 = n_lasts;
        w0 = n_words;
        wait_lasts(l0, 300, "frame1_done");
        chk("frame1_words", n_words - w0, NCH);
        wait_conv(300, "frame2_conv");
        chk("conv_period", last_conv_t - prev_conv_t, SDIV);
        wait_lasts(n_lasts, 300, "frame2_done");

        // backpressure scenarios
        for (int i = 0; i < 4; i++) begin
            wait_conv(600, "stall_conv");
            stall_word = tbl[i].word;
            stall_len = tbl[i].len;
            stall_gen++;
            l0 = n_lasts;
            w0 = n_words;
            wait_lasts(l0, 800, "stall_frame_done");
            repeat (3) step();
            chk("stall_words", n_words - w0, NCH);
            chk("stall_overrun", err_overrun, tbl[i].ovr);
            pulse_clr();
            chk("overrun_cleared", err_overrun, 0);
        end

        // FRSTDATA missing on word 0
        bad_frst = 1'b1;
        wait_conv(600, "frst_conv");
        w0 = n_words;
        repeat (150) step();
        chk("frst_err", err_frst, FRST_CHK);
        chk("frst_words", n_words - w0, FRST_CHK ? 0 : NCH);
        bad_frst = 1'b0;
        pulse_clr();
        chk("frst_cleared", err_frst, 0);

        // BUSY stuck high: timeout, chip re-reset, recovery
        busy_len = 1_000_000;
        wait_conv(600, "tmo_conv");
        busy_len = 20;
        cnt = 0;
        while (!err_timeout && cnt < 5000) begin cnt++; step(); end
        chk("timeout_latency", cnt, 3 + 6 + 4096);
        cnt = 0;
        while (ad_reset && cnt < 100) begin cnt++; step(); end
        chk("rereset_width", cnt, 16);
        chk("timeout_sticky", err_timeout, 1);
        wait_lasts(n_lasts, 800, "tmo_recover");
        pulse_clr();
        chk("timeout_cleared", {err_timeout, err_overrun}, 0);

        // rst_n asserted while word 2 is stalled
        stall_word = 2;
        stall_len = 50;
        stall_gen++;
        cnt = 0;
        while (!(m_valid && m_ch == 3'd2) && cnt < 600) begin cnt++; step(); end
        chk("midrst_reached", m_valid && m_ch == 3'd2, 1);
        rst_n = 1'b0;
        step();
        chk("midrst_outs", {ad_reset, m_valid, ad_cs_n, ad_rd_n, ad_convst}, 5'b10111);
        rst_n = 1'b1;
        cnt = 0;
        while (ad_reset && cnt < 100) begin cnt++; step(); end
        chk("midrst_reset_width", cnt, 16);
        wait_lasts(n_lasts, 800, "midrst_recover");

        // enable dropped mid-frame: frame completes, no new conversion
        wait_conv(600, "en_conv");
        enable = 1'b0;
        l0 = n_lasts;
        c0 = n_conv;
        repeat (700) step();
        chk("en_frame_done", n_lasts - l0, 1);
        chk("en_no_conv", n_conv - c0, 0);
        enable = 1'b1;

        // randomized traffic
        rand_mode = 1'b1;
        repeat (15000) step();
        rand_mode = 1'b0;
        wait_conv(600, "rand_tail_conv");
        wait_lasts(n_lasts, 800, "rand_tail_done");
        repeat (3) step();
        chk("queue_drained", exp_q.size(), 0);
        chk("rand_no_timeout", err_timeout, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
